// File: rtl/csam_pipe_mult.sv
// Pipelined carry-save array multiplier, signed (Baugh-Wooley) or unsigned per operation; optional accumulate under CSAM_ACC_EN.
// Latency: p/out_valid update STAGES rising edges after the accepting edge; one op per cycle sustained.
// Backpressure: one global enable (!out_valid || out_ready) freezes every stage; in_ready mirrors it.
module csam_pipe_mult #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    input  logic               signed_mode,
`ifdef CSAM_ACC_EN
    input  logic               acc_en,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p
);
    localparam int W2  = 2 * WIDTH;
    localparam int RPS = WIDTH / STAGES;

    typedef struct packed {
        logic [W2-1:0] s;
        logic [W2-1:0] c;
    } cs_t;

    logic              en;
    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] sm_q;
    logic [WIDTH-1:0]  x_q  [STAGES];
    logic [WIDTH-1:0]  y_q  [STAGES];
    cs_t               cs_q [STAGES];
    cs_t               cs_d [STAGES];
    logic              out_valid_q;
    logic [W2-1:0]     p_q;
    logic [W2-1:0]     p_d;
    logic [W2-1:0]     prod;
`ifdef CSAM_ACC_EN
    logic [STAGES-1:0] ae_q;
    logic [W2-1:0]     acc_q;
`endif

    function automatic cs_t csa3(input cs_t cin, input logic [W2-1:0] row);
        cs_t r;
        r.s = cin.s ^ cin.c ^ row;
        r.c = ((cin.s & cin.c) | (cin.s & row) | (cin.c & row)) << 1;
        return r;
    endfunction

    // Folds RPS rows of the AND-array, starting at row 'first', into the sum/carry pair.
    // Baugh-Wooley: cells in exactly one of the MSB row / MSB column are inverted.
    function automatic cs_t reduce(input cs_t cin, input logic [WIDTH-1:0] a,
                                   input logic [WIDTH-1:0] b, input logic sm, input int first);
        cs_t           r;
        logic [W2-1:0] row;
        r = cin;
        for (int i = 0; i < RPS; i++) begin
            row = '0;
            for (int j = 0; j < WIDTH; j++)
                row[first+i+j] = (a[j] & b[first+i]) ^ (sm && ((first + i == WIDTH - 1) != (j == WIDTH - 1)));
            r = csa3(r, row);
        end
        if (first == 0 && sm)
            r = csa3(r, (W2'(1) << WIDTH) | (W2'(1) << (W2 - 1)));
        return r;
    endfunction

    assign en        = !out_valid_q || out_ready;
    assign in_ready  = en;
    assign out_valid = out_valid_q;
    assign p         = p_q;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign cs_d[k] = reduce(cs_t'('0), x_q[k], y_q[k], sm_q[k], 0);
        end else begin : g_rest
            assign cs_d[k] = reduce(cs_q[k], x_q[k], y_q[k], sm_q[k], k * RPS);
        end
    end

    assign prod = cs_d[STAGES-1].s + cs_d[STAGES-1].c;
`ifdef CSAM_ACC_EN
    assign p_d = prod + (ae_q[STAGES-1] ? acc_q : '0);
`else
    assign p_d = prod;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q       <= '0;
            sm_q        <= '0;
            out_valid_q <= 1'b0;
            p_q         <= '0;
            for (int l = 0; l < STAGES; l++) begin
                x_q[l]  <= '0;
                y_q[l]  <= '0;
                cs_q[l] <= '0;
            end
`ifdef CSAM_ACC_EN
            ae_q  <= '0;
            acc_q <= '0;
`endif
        end else if (en) begin
            vld_q[0] <= in_valid;
            if (in_valid) begin
                x_q[0]  <= x;
                y_q[0]  <= y;
                sm_q[0] <= signed_mode;
`ifdef CSAM_ACC_EN
                ae_q[0] <= acc_en;
`endif
            end
            // Data registers only load behind a valid slot; bubbles just move the valid bit.
            for (int l = 1; l < STAGES; l++) begin
                vld_q[l] <= vld_q[l-1];
                if (vld_q[l-1]) begin
                    x_q[l]  <= x_q[l-1];
                    y_q[l]  <= y_q[l-1];
                    sm_q[l] <= sm_q[l-1];
                    cs_q[l] <= cs_d[l-1];
`ifdef CSAM_ACC_EN
                    ae_q[l] <= ae_q[l-1];
`endif
                end
            end
            out_valid_q <= vld_q[STAGES-1];
            if (vld_q[STAGES-1]) begin
                p_q <= p_d;
`ifdef CSAM_ACC_EN
                acc_q <= p_d;
`endif
            end
        end
    end
endmodule

// File: tb/tb_csam_pipe_mult.sv
// Scoreboard bench for csam_pipe_mult (WIDTH=16, STAGES=4): directed table, random stream, backpressure, async reset.
module tb_csam_pipe_mult;
    localparam int W = 16;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] x_in = '0;
    logic [W-1:0] y_in = '0;
    logic         sm_in = 1'b0;
`ifdef CSAM_ACC_EN
    logic         ae_in = 1'b0;
`endif
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [2*W-1:0] p;

    always #5 clk = ~clk;

    csam_pipe_mult #(.WIDTH(W), .STAGES(S)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x(x_in), .y(y_in), .signed_mode(sm_in),
`ifdef CSAM_ACC_EN
        .acc_en(ae_in),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .p(p)
    );

    typedef struct {
        logic [31:0] exp;
        int          acc_cyc;
    } sb_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sm;
        logic [31:0] exp;
    } vec_t;

    sb_t  sbq[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   n_out = 0;
    int   stalls = 0;
    bit   lat_chk = 1'b1;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b, input logic sm);
        longint sa;
        longint sb;
        sa = sm ? longint'($signed(a)) : longint'(a);
        sb = sm ? longint'($signed(b)) : longint'(b);
        return 32'(sa * sb);
    endfunction

    always @(negedge clk) begin : mon
        sb_t e;
        if (rst_n && out_valid && out_ready) begin
            n_out++;
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output actual=%0h required=no_output", p);
            end else begin
                e = sbq.pop_front();
                chk("p", p, e.exp);
                if (lat_chk) chk("latency", cyc - e.acc_cyc, S);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic sm, input logic [31:0] exp);
        int t = 0;
        x_in = a; y_in = b; sm_in = sm; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            t++;
            @(negedge clk);
        end
        if (t != 0) stalls++;
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=in_ready_low required=accept");
        end else begin
            sbq.push_back('{exp, cyc + 1});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int t = 0;
        in_valid = 1'b0;
        while (sbq.size() != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        if (sbq.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d required=0", sbq.size());
            sbq.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "simulation timeout");
    end

    initial begin : main
        vec_t        tbl[9];
        logic [15:0] ba[6];
        logic [15:0] bb[6];
        logic        bs[6];
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rs;
        logic [31:0] p_hold;
        int          idx;
        int          n_acc;
        int          p_chg;
        int          n_before;
        int          stray;
        bit          held;

        tbl[0] = '{16'hFFFD, 16'h0005, 1'b1, 32'hFFFFFFF1};
        tbl[1] = '{16'h8000, 16'h8000, 1'b1, 32'h40000000};
        tbl[2] = '{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001};
        tbl[3] = '{16'h1234, 16'h0000, 1'b0, 32'h00000000};
        tbl[4] = '{16'h7FFF, 16'h7FFF, 1'b1, 32'h3FFF0001};
        tbl[5] = '{16'h8000, 16'h7FFF, 1'b1, 32'hC0008000};
        tbl[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001};
        tbl[7] = '{16'h8000, 16'h0001, 1'b0, 32'h00008000};
        tbl[8] = '{16'h0007, 16'h0009, 1'b0, 32'h0000003F};

        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_p", p, 0);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_in_ready", in_ready, 1);
        chk("idle_out_valid", out_valid, 0);

        for (int i = 0; i < 9; i++) send(tbl[i].a, tbl[i].b, tbl[i].sm, tbl[i].exp);
        drain();

        stalls = 0;
        n_before = n_out;
        for (int i = 0; i < 100; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom_range(0, 1));
            send(ra, rb, rs, model(ra, rb, rs));
        end
        drain();
        chk("thru_stalls", stalls, 0);
        chk("thru_count", n_out - n_before, 100);

        lat_chk = 1'b0;
        for (int i = 0; i < 6; i++) begin
            ba[i] = 16'(i * 311 + 17);
            bb[i] = 16'(16'hF000 + i * 7);
            bs[i] = 1'(i % 2);
        end
        out_ready = 1'b0;
        idx = 0; n_acc = 0; p_chg = 0; held = 1'b0; p_hold = '0;
        for (int c = 0; c < 10; c++) begin
            in_valid = (idx < 6);
            if (idx < 6) begin
                x_in = ba[idx]; y_in = bb[idx]; sm_in = bs[idx];
            end
            @(negedge clk);
            if (in_valid && in_ready) begin
                sbq.push_back('{model(ba[idx], bb[idx], bs[idx]), cyc + 1});
                idx++;
                n_acc++;
            end
            if (out_valid) begin
                if (!held) begin
                    p_hold = p;
                    held = 1'b1;
                end else if (p !== p_hold) begin
                    p_chg++;
                end
            end
            @(posedge clk);
            #1;
        end
        chk("bp_accepted", n_acc, S + 1);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        chk("bp_p_stable", p_chg, 0);
        chk("bp_p_first", p_hold, model(ba[0], bb[0], bs[0]));
        n_before = n_out;
        out_ready = 1'b1;
        while (idx < 6) begin
            send(ba[idx], bb[idx], bs[idx], model(ba[idx], bb[idx], bs[idx]));
            idx++;
        end
        drain();
        chk("bp_out_count", n_out - n_before, 6);

        out_ready = 1'b0;
        send(16'd3, 16'd5, 1'b0, 32'd15);
        send(16'd11, 16'd13, 1'b0, 32'd143);
        send(16'hFFFE, 16'd4, 1'b1, 32'hFFFFFFF8);
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #3;
        chk("rst_pre_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", out_valid, 0);
        chk("rst_async_p", p, 0);
        sbq.delete();
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        stray = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid) stray++;
        end
        chk("rst_no_stale", stray, 0);
        @(posedge clk);
        #1;
        lat_chk = 1'b1;
        send(16'd7, 16'd9, 1'b0, 32'd63);
        drain();

`ifdef CSAM_ACC_EN
        ae_in = 1'b0; send(16'd2, 16'd3, 1'b0, 32'd6);
        ae_in = 1'b1; send(16'd4, 16'd5, 1'b0, 32'd26);
        ae_in = 1'b1; send(16'd1, 16'd1, 1'b0, 32'd27);
        ae_in = 1'b0; send(16'd7, 16'd7, 1'b0, 32'd49);
        drain();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
